// File: rtl/rv32i_types.sv
// Shared pipeline types: skid-register state encoding and per-entry update operations.
package rv32i_types;

  localparam int PIPE_SKID_OCC_W = 2;

  typedef enum logic [1:0] {
    PSK_EMPTY = 2'd0,
    PSK_BUSY  = 2'd1,
    PSK_FULL  = 2'd2
  } pipe_skid_state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD      = 2'd0,
    MAIN_LOAD_IN   = 2'd1,
    MAIN_LOAD_SKID = 2'd2,
    MAIN_CLEAR     = 2'd3
  } pipe_skid_main_op_t;

  typedef enum logic [1:0] {
    SKID_HOLD    = 2'd0,
    SKID_LOAD_IN = 2'd1,
    SKID_CLEAR   = 2'd2
  } pipe_skid_skid_op_t;

  // State encoding doubles as the held-entry count.
  function automatic logic [PIPE_SKID_OCC_W-1:0] psk_occupancy(input pipe_skid_state_t st);
    case (st)
      PSK_BUSY: psk_occupancy = 2'd1;
      PSK_FULL: psk_occupancy = 2'd2;
      default:  psk_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register cutting the ready path between pipeline stages.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module pipe_skid_reg
  import rv32i_types::*;
#(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_EMPTY = 1'b1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [PIPE_SKID_OCC_W-1:0] occupancy_o,
  output logic [CNT_WIDTH-1:0]       stall_cnt_o,
  output pipe_skid_state_t           dbg_state_o
);

  pipe_skid_state_t   r_state;
  pipe_skid_state_t   w_state_nxt;
  pipe_skid_main_op_t w_main_op;
  pipe_skid_skid_op_t w_skid_op;

  logic [WIDTH-1:0]     r_main;
  logic [WIDTH-1:0]     r_skid;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  // Ready is decoded from registered state only, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (r_state != PSK_FULL);
  assign out_valid_o = (r_state != PSK_EMPTY);
  assign out_data_o  = r_main;
  assign occupancy_o = psk_occupancy(r_state);
  assign stall_cnt_o = r_stall_cnt;
  assign dbg_state_o = r_state;

  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_out_fire = out_valid_o & out_ready_i;
  assign w_stall    = out_valid_o & ~out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_op   = MAIN_HOLD;
    w_skid_op   = SKID_HOLD;
    if (flush_i) begin
      w_state_nxt = PSK_EMPTY;
      w_main_op   = MAIN_CLEAR;
      w_skid_op   = SKID_CLEAR;
    end else begin
      case (r_state)
        PSK_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = PSK_BUSY;
            w_main_op   = MAIN_LOAD_IN;
          end
        end
        PSK_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_op = MAIN_LOAD_IN;
          end else if (w_in_fire) begin
            w_state_nxt = PSK_FULL;
            w_skid_op   = SKID_LOAD_IN;
          end else if (w_out_fire) begin
            w_state_nxt = PSK_EMPTY;
            w_main_op   = MAIN_CLEAR;
          end
        end
        PSK_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = PSK_BUSY;
            w_main_op   = MAIN_LOAD_SKID;
            w_skid_op   = SKID_CLEAR;
          end
        end
        default: begin
          w_state_nxt = PSK_EMPTY;
          w_main_op   = MAIN_CLEAR;
          w_skid_op   = SKID_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PSK_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear operations only zero an entry when bubbles are requested; otherwise stale data stays.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
    end else begin
      case (w_main_op)
        MAIN_LOAD_IN:   r_main <= in_data_i;
        MAIN_LOAD_SKID: r_main <= r_skid;
        MAIN_CLEAR:     if (CLEAR_ON_EMPTY) r_main <= '0;
        default:        r_main <= r_main;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid <= '0;
    end else begin
      case (w_skid_op)
        SKID_LOAD_IN: r_skid <= in_data_i;
        SKID_CLEAR:   if (CLEAR_ON_EMPTY) r_skid <= '0;
        default:      r_skid <= r_skid;
      endcase
    end
  end

  // Flush does not touch the counter: a flushed stall cycle was still a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vectors on a 32-bit instance, counter saturation on a
// 4-bit-counter instance, and a scoreboarded random valid/ready run on a 7-bit instance.
module tb_pipe_skid_reg;
  import rv32i_types::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults.
  logic             a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0]      a_in_data, a_out_data, a_stall;
  logic [1:0]       a_occ;
  pipe_skid_state_t a_dbg;

  pipe_skid_reg u_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .in_valid_i(a_in_valid), .in_data_i(a_in_data),
    .in_ready_o(a_in_ready), .out_valid_o(a_out_valid), .out_data_o(a_out_data),
    .out_ready_i(a_out_ready), .occupancy_o(a_occ), .stall_cnt_o(a_stall), .dbg_state_o(a_dbg)
  );

  // Instance B: 4-bit stall counter.
  logic             b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0]      b_in_data, b_out_data;
  logic [3:0]       b_stall;
  logic [1:0]       b_occ;
  pipe_skid_state_t b_dbg;

  pipe_skid_reg #(.CNT_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .in_valid_i(b_in_valid), .in_data_i(b_in_data),
    .in_ready_o(b_in_ready), .out_valid_o(b_out_valid), .out_data_o(b_out_data),
    .out_ready_i(b_out_ready), .occupancy_o(b_occ), .stall_cnt_o(b_stall), .dbg_state_o(b_dbg)
  );

  // Instance C: 7-bit payload, random traffic.
  logic             c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [6:0]       c_in_data, c_out_data;
  logic [31:0]      c_stall;
  logic [1:0]       c_occ;
  pipe_skid_state_t c_dbg;

  pipe_skid_reg #(.WIDTH(7)) u_c (
    .clk(clk), .rst(rst), .flush_i(c_flush), .in_valid_i(c_in_valid), .in_data_i(c_in_data),
    .in_ready_o(c_in_ready), .out_valid_o(c_out_valid), .out_data_o(c_out_data),
    .out_ready_i(c_out_ready), .occupancy_o(c_occ), .stall_cnt_o(c_stall), .dbg_state_o(c_dbg)
  );

  logic [6:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = rdy;
    a_flush     = fl;
  endtask

  task automatic a_expect(input string tag, input logic v, input logic [31:0] d,
                          input logic [1:0] occ, input logic rdy, input logic [31:0] st);
    check_eq({tag, "_valid"}, 64'(a_out_valid), 64'(v));
    check_eq({tag, "_data"},  64'(a_out_data),  64'(d));
    check_eq({tag, "_occ"},   64'(a_occ),       64'(occ));
    check_eq({tag, "_ready"}, 64'(a_in_ready),  64'(rdy));
    check_eq({tag, "_stall"}, 64'(a_stall),     64'(st));
  endtask

  initial begin
    int    in_fire;
    int    out_fire;
    int    exp_stall;
    logic [6:0] exp_d;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_drive(1'b1, 32'h5555, 1'b0, 1'b1);
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    #1;

    // Reset: valid/flush ignored while rst is high.
    step();
    step();
    a_expect("rst", 1'b0, 32'h0, 2'd0, 1'b1, 32'd0);
    rst = 1'b0;
    a_drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    a_expect("idle", 1'b0, 32'h0, 2'd0, 1'b1, 32'd0);

    // Streaming at full rate.
    a_drive(1'b1, 32'h11, 1'b1, 1'b0); step(); a_expect("s11", 1'b1, 32'h11, 2'd1, 1'b1, 32'd0);
    a_drive(1'b1, 32'h22, 1'b1, 1'b0); step(); a_expect("s22", 1'b1, 32'h22, 2'd1, 1'b1, 32'd0);
    a_drive(1'b1, 32'h33, 1'b1, 1'b0); step(); a_expect("s33", 1'b1, 32'h33, 2'd1, 1'b1, 32'd0);
    a_drive(1'b0, 32'h0,  1'b1, 1'b0); step(); a_expect("sdrain", 1'b0, 32'h0, 2'd0, 1'b1, 32'd0);

    // Back-pressure fills the skid entry, then drains in order.
    a_drive(1'b1, 32'hA, 1'b0, 1'b0); step(); a_expect("bpA", 1'b1, 32'hA, 2'd1, 1'b1, 32'd0);
    a_drive(1'b1, 32'hB, 1'b0, 1'b0); step(); a_expect("bpB", 1'b1, 32'hA, 2'd2, 1'b0, 32'd1);
    a_drive(1'b0, 32'h0, 1'b0, 1'b0); step(); a_expect("bph1", 1'b1, 32'hA, 2'd2, 1'b0, 32'd2);
    step();                                   a_expect("bph2", 1'b1, 32'hA, 2'd2, 1'b0, 32'd3);
    a_drive(1'b0, 32'h0, 1'b1, 1'b0); step(); a_expect("bpoB", 1'b1, 32'hB, 2'd1, 1'b1, 32'd3);
    step();                                   a_expect("bpend", 1'b0, 32'h0, 2'd0, 1'b1, 32'd3);

    // Flush while full with a valid input: input is dropped, counter still counts the stall.
    a_drive(1'b1, 32'h1, 1'b0, 1'b0); step(); a_expect("fl1", 1'b1, 32'h1, 2'd1, 1'b1, 32'd3);
    a_drive(1'b1, 32'h2, 1'b0, 1'b0); step(); a_expect("fl2", 1'b1, 32'h1, 2'd2, 1'b0, 32'd4);
    a_drive(1'b1, 32'hC, 1'b0, 1'b1); step(); a_expect("flush", 1'b0, 32'h0, 2'd0, 1'b1, 32'd5);
    a_drive(1'b0, 32'h0, 1'b1, 1'b0); step(); a_expect("flpost", 1'b0, 32'h0, 2'd0, 1'b1, 32'd5);

    // Reset in BUSY discards the held payload.
    a_drive(1'b1, 32'hDEAD, 1'b0, 1'b0); step(); a_expect("busy", 1'b1, 32'hDEAD, 2'd1, 1'b1, 32'd5);
    rst = 1'b1;
    a_drive(1'b1, 32'hBEEF, 1'b0, 1'b0); step(); a_expect("midrst", 1'b0, 32'h0, 2'd0, 1'b1, 32'd0);
    rst = 1'b0;
    a_drive(1'b0, 32'h0, 1'b1, 1'b0); step(); a_expect("postrst", 1'b0, 32'h0, 2'd0, 1'b1, 32'd0);

    // Stall counter saturation on the 4-bit instance.
    b_in_valid = 1'b1; b_in_data = 32'h77; b_out_ready = 1'b0;
    step();
    check_eq("sat_load", 64'(b_out_data), 64'h77);
    check_eq("sat_c0", 64'(b_stall), 64'd0);
    b_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) check_eq("sat_c14", 64'(b_stall), 64'd14);
      if (k == 15) check_eq("sat_c15", 64'(b_stall), 64'd15);
    end
    check_eq("sat_c20", 64'(b_stall), 64'd15);
    check_eq("sat_occ", 64'(b_occ), 64'd1);

    // Random traffic against the scoreboard; the model is just a queue and a stall count.
    exp_stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      c_in_valid  = 1'($urandom_range(0, 1));
      c_out_ready = 1'($urandom_range(0, 1));
      c_in_data   = 7'($urandom_range(0, 127));
      // Flipping out_ready mid-cycle must not move in_ready.
      c_out_ready = ~c_out_ready;
      #1;
      check_eq("c_ready_comb", 64'(c_in_ready), 64'(exp_q.size() < 2));
      c_out_ready = ~c_out_ready;
      #1;
      in_fire  = (c_in_valid && exp_q.size() < 2) ? 1 : 0;
      out_fire = (c_out_ready && exp_q.size() > 0) ? 1 : 0;
      if (exp_q.size() > 0 && !c_out_ready) exp_stall++;
      if (out_fire != 0) begin
        exp_d = exp_q.pop_front();
        check_eq("c_data", 64'(c_out_data), 64'(exp_d));
      end
      if (in_fire != 0) exp_q.push_back(c_in_data);
      step();
      check_eq("c_occ", 64'(c_occ), 64'(exp_q.size()));
    end
    check_eq("c_stall", 64'(c_stall), 64'(exp_stall));
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        check_eq("c_drain", 64'(c_out_data), 64'(exp_d));
      end
      step();
    end
    check_eq("c_empty", 64'(c_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
